// File: rtl/bp_pkg.sv
// Shared definitions for the dynamic branch predictor.
//   OP_BRANCH / OP_JAL / OP_JALR : RV32 control-transfer opcodes
//   ctr_t                        : 2-bit saturating direction counter
//   bp_entry_t                   : per-entry status (valid bit + counter);
//                                  tag and target live in XLEN-sized arrays
//                                  in the top so XLEN stays a parameter.
//   is_control()                 : opcode classifier
package bp_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic valid;
    ctr_t ctr;
  } bp_entry_t;

  localparam bp_entry_t ENTRY_RESET = '{valid: 1'b0, ctr: WNT};

  function automatic logic is_control(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational next-state of a 2-bit saturating direction counter.
//   ctr      : current counter value
//   taken    : resolved branch outcome
//   ctr_next : ctr+1 if taken, ctr-1 if not, clamped at ST / SNT
module bp_sat_counter
  import bp_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t ctr_next
);

  logic [1:0] ctr_bits;

  always_comb begin
    ctr_bits = ctr;
    if (taken) begin
      if (ctr != ST) ctr_bits = ctr_bits + 2'd1;
    end else begin
      if (ctr != SNT) ctr_bits = ctr_bits - 2'd1;
    end
    ctr_next = ctr_t'(ctr_bits);
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped dynamic branch predictor (fetch lookup + execute feedback).
// Parameters: ENTRIES (power of two, >=2), XLEN (address width).
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   if_pc                     : fetch PC looked up combinationally
//   pred_taken, pred_target   : prediction for if_pc (target = if_pc+4 if not taken)
//   ex_valid, ex_stall        : execute-stage qualifiers; resolve = valid & ~stall
//   ex_pc, ex_opcode          : execute-stage instruction identity
//   ex_br_taken, ex_target    : resolved outcome and target
//   ex_pred_taken/_target     : prediction carried down with the instruction
//   mispredict, redirect_pc   : combinational flush request and correct next PC
// Optional feature macro BP_PERF_EN adds perf_branches / perf_mispredicts
// (32-bit wrapping counters of control resolves and mispredict cycles).
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [6:0]      ex_opcode,
  input  logic            ex_br_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
`ifdef BP_PERF_EN
  ,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
`endif
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = XLEN - IW - 2;

  // Table read views, driven from the per-entry flops below.
  bp_entry_t       entry_q  [ENTRIES];
  logic [TW-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0] target_q [ENTRIES];

  // PC bits [1:0] never participate in index or tag.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  // ---------------- fetch lookup ----------------
  logic [IW-1:0] if_idx;
  logic [TW-1:0] if_tag;
  bp_entry_t     if_ent;
  logic          if_hit;

  assign if_idx      = if_pc[IW+1:2];
  assign if_tag      = if_pc[XLEN-1:IW+2];
  assign if_ent      = entry_q[if_idx];
  assign if_hit      = if_ent.valid && (tag_q[if_idx] == if_tag);
  assign pred_taken  = if_hit && if_ent.ctr[1];
  assign pred_target = pred_taken ? target_q[if_idx] : if_pc + XLEN'(4);

  // ---------------- execute resolve ----------------
  logic [IW-1:0]   ex_idx;
  logic [TW-1:0]   ex_tag;
  bp_entry_t       ex_ent;
  logic            ex_hit;
  logic            ex_is_branch;
  logic            ctl_ev;
  logic            stale_ev;
  logic [XLEN-1:0] ex_seq_pc;

  assign ex_idx       = ex_pc[IW+1:2];
  assign ex_tag       = ex_pc[XLEN-1:IW+2];
  assign ex_ent       = entry_q[ex_idx];
  assign ex_hit       = ex_ent.valid && (tag_q[ex_idx] == ex_tag);
  assign ex_is_branch = (ex_opcode == OP_BRANCH);
  assign ex_seq_pc    = ex_pc + XLEN'(4);

  // rst gates the resolve so flush outputs are quiet while reset is held.
  assign ctl_ev   = ex_valid && !ex_stall && !rst && is_control(ex_opcode);
  // A non-control instruction that was predicted taken hit an entry whose
  // owner has been replaced by straight-line code: fall through and drop it.
  assign stale_ev = ex_valid && !ex_stall && !rst && !is_control(ex_opcode) && ex_pred_taken;

  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = ex_seq_pc;
    if (ctl_ev) begin
      mispredict  = (ex_br_taken != ex_pred_taken) ||
                    (ex_br_taken && (ex_pred_target != ex_target));
      redirect_pc = ex_br_taken ? ex_target : ex_seq_pc;
    end else if (stale_ev) begin
      mispredict  = 1'b1;
    end
  end

  // ---------------- table update ----------------
  ctr_t            sat_next;
  logic            upd_en;
  bp_entry_t       upd_entry;
  logic [TW-1:0]   upd_tag;
  logic [XLEN-1:0] upd_target;

  bp_sat_counter u_sat (
    .ctr      (ex_ent.ctr),
    .taken    (ex_br_taken),
    .ctr_next (sat_next)
  );

  always_comb begin
    upd_en     = 1'b0;
    upd_entry  = ex_ent;
    upd_tag    = tag_q[ex_idx];
    upd_target = target_q[ex_idx];
    if (ctl_ev) begin
      if (ex_hit) begin
        upd_en        = 1'b1;
        upd_entry.ctr = ex_is_branch ? sat_next : ST;
        if (ex_br_taken) upd_target = ex_target;
      end else if (ex_br_taken) begin
        // Allocate on a taken miss; jumps start strongly taken.
        upd_en          = 1'b1;
        upd_entry.valid = 1'b1;
        upd_entry.ctr   = ex_is_branch ? WT : ST;
        upd_tag         = ex_tag;
        upd_target      = ex_target;
      end
    end else if (stale_ev) begin
      upd_en          = 1'b1;
      upd_entry.valid = 1'b0;
    end
  end

  // Flop-based storage so reset can clear every entry.
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    localparam logic [IW-1:0] IDX = gi[IW-1:0];

    bp_entry_t       entry_reg;
    logic [TW-1:0]   tag_reg;
    logic [XLEN-1:0] target_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        entry_reg  <= ENTRY_RESET;
        tag_reg    <= '0;
        target_reg <= '0;
      end else if (upd_en && (ex_idx == IDX)) begin
        entry_reg  <= upd_entry;
        tag_reg    <= upd_tag;
        target_reg <= upd_target;
      end
    end

    assign entry_q[gi]  = entry_reg;
    assign tag_q[gi]    = tag_reg;
    assign target_q[gi] = target_reg;
  end

`ifdef BP_PERF_EN
  logic [31:0] perf_branches_reg;
  logic [31:0] perf_mispredicts_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_branches_reg    <= '0;
      perf_mispredicts_reg <= '0;
    end else begin
      if (ctl_ev)     perf_branches_reg    <= perf_branches_reg + 32'd1;
      if (mispredict) perf_mispredicts_reg <= perf_mispredicts_reg + 32'd1;
    end
  end

  assign perf_branches    = perf_branches_reg;
  assign perf_mispredicts = perf_mispredicts_reg;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor (ENTRIES=16, XLEN=32).
// Define BP_PERF_EN to also exercise the performance counters.
module tb_branch_predictor;

  localparam logic [6:0] OPB = 7'b1100011;
  localparam logic [6:0] OPJ = 7'b1101111;
  localparam logic [6:0] OPR = 7'b1100111;
  localparam logic [6:0] OPA = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_stall, ex_br_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic [6:0]  ex_opcode;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BP_PERF_EN
  logic [31:0] perf_branches, perf_mispredicts;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  branch_predictor #(.ENTRIES(16), .XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_stall       (ex_stall),
    .ex_pc          (ex_pc),
    .ex_opcode      (ex_opcode),
    .ex_br_taken    (ex_br_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc)
`ifdef BP_PERF_EN
    ,
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic st, input logic [31:0] pc, input logic [6:0] op,
                          input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
    ex_valid       = 1'b1;
    ex_stall       = st;
    ex_pc          = pc;
    ex_opcode      = op;
    ex_br_taken    = tk;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
    #1;
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0;
    ex_stall = 1'b0;
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    if_pc = pc;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    if_pc = 32'h100;
    ex_valid = 0; ex_stall = 0; ex_pc = 32'h10; ex_opcode = OPA;
    ex_br_taken = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
    tick(); tick();

    // Resolve presented while reset is held must not flush.
    drive_ex(0, 32'h100, OPB, 1, 32'h80, 0, 32'h104);
    check("rst_mispredict", {31'd0, mispredict}, 32'd0);
    check("rst_redirect", redirect_pc, 32'h104);
    check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    rst = 1'b0;
    idle_ex();
    check("init_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("init_pred_target", pred_target, 32'h104);
    check("init_mispredict", {31'd0, mispredict}, 32'd0);

    // First taken resolve allocates; same-cycle lookup sees old contents.
    drive_ex(0, 32'h100, OPB, 1, 32'h80, 0, 32'h104);
    check("alloc_mispredict", {31'd0, mispredict}, 32'd1);
    check("alloc_redirect", redirect_pc, 32'h80);
    check("no_bypass", {31'd0, pred_taken}, 32'd0);
    tick(); idle_ex();
    check("alloc_pred_taken", {31'd0, pred_taken}, 32'd1);
    check("alloc_pred_target", pred_target, 32'h80);

    // Not-taken three times: 10 -> 01 -> 00 -> 00.
    drive_ex(0, 32'h100, OPB, 0, 32'h80, 1, 32'h80);
    check("nt1_mispredict", {31'd0, mispredict}, 32'd1);
    check("nt1_redirect", redirect_pc, 32'h104);
    tick(); idle_ex();
    check("nt1_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("nt1_pred_target", pred_target, 32'h104);
    drive_ex(0, 32'h100, OPB, 0, 32'h80, 0, 32'h104);
    check("nt2_mispredict", {31'd0, mispredict}, 32'd0);
    tick();
    drive_ex(0, 32'h100, OPB, 0, 32'h80, 0, 32'h104);
    tick();
    // Counter sits at 00; one taken must only reach 01.
    drive_ex(0, 32'h100, OPB, 1, 32'h90, 0, 32'h104);
    check("t1_redirect", redirect_pc, 32'h90);
    tick(); idle_ex();
    check("sat_low_pred", {31'd0, pred_taken}, 32'd0);
    drive_ex(0, 32'h100, OPB, 1, 32'h90, 0, 32'h104);
    tick(); idle_ex();
    check("t2_pred_taken", {31'd0, pred_taken}, 32'd1);
    check("t2_pred_target", pred_target, 32'h90);

    // JALR at 0x200 (same index as 0x100, different tag).
    look(32'h200);
    check("jalr_miss_pred", {31'd0, pred_taken}, 32'd0);
    drive_ex(0, 32'h200, OPR, 1, 32'h300, 0, 32'h204);
    check("jalr1_mispredict", {31'd0, mispredict}, 32'd1);
    check("jalr1_redirect", redirect_pc, 32'h300);
    tick(); idle_ex();
    check("jalr1_pred_target", pred_target, 32'h300);
    look(32'h100);
    check("evicted_pred", {31'd0, pred_taken}, 32'd0);
    drive_ex(0, 32'h200, OPR, 1, 32'h400, 1, 32'h300);
    check("jalr2_mispredict", {31'd0, mispredict}, 32'd1);
    check("jalr2_redirect", redirect_pc, 32'h400);
    tick(); idle_ex();
    look(32'h200);
    check("jalr2_pred_target", pred_target, 32'h400);
    drive_ex(0, 32'h200, OPR, 1, 32'h400, 1, 32'h400);
    check("jalr3_mispredict", {31'd0, mispredict}, 32'd0);
    tick(); idle_ex();

    // Aliased PC 0x200 + 4*16 misses.
    look(32'h240);
    check("alias_pred", {31'd0, pred_taken}, 32'd0);
    check("alias_target", pred_target, 32'h244);

    // Stale predicted-taken non-control instruction.
    drive_ex(0, 32'h200, OPA, 0, 32'h0, 1, 32'h400);
    check("stale_mispredict", {31'd0, mispredict}, 32'd1);
    check("stale_redirect", redirect_pc, 32'h204);
    tick(); idle_ex();
    look(32'h200);
    check("stale_invalidated", {31'd0, pred_taken}, 32'd0);

    // Stalled resolve: no flush, no update.
    drive_ex(1, 32'h104, OPB, 1, 32'h500, 0, 32'h108);
    check("stall_mispredict", {31'd0, mispredict}, 32'd0);
    check("stall_redirect", redirect_pc, 32'h108);
    tick(); idle_ex();
    look(32'h104);
    check("stall_no_alloc", {31'd0, pred_taken}, 32'd0);

    // JAL allocates strongly taken: one not-taken leaves it predicted taken.
    drive_ex(0, 32'h108, OPJ, 1, 32'h600, 0, 32'h10c);
    tick();
    drive_ex(0, 32'h108, OPB, 0, 32'h600, 1, 32'h600);
    check("jal_nt_redirect", redirect_pc, 32'h10c);
    tick(); idle_ex();
    look(32'h108);
    check("jal_st_pred", {31'd0, pred_taken}, 32'd1);
    check("jal_st_target", pred_target, 32'h600);

    // +4 wraps at the top of the address space.
    drive_ex(0, 32'hFFFF_FFFC, OPA, 0, 32'h0, 0, 32'h0);
    check("wrap_redirect", redirect_pc, 32'h0);
    check("wrap_mispredict", {31'd0, mispredict}, 32'd0);
    idle_ex();
    look(32'hFFFF_FFFC);
    check("wrap_pred_target", pred_target, 32'h0);

    // Asynchronous reset mid-cycle clears predictions immediately.
    look(32'h108);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pred", {31'd0, pred_taken}, 32'd0);
    check("async_rst_target", pred_target, 32'h10c);
    tick();
    rst = 1'b0;
    #1;

`ifdef BP_PERF_EN
    check("perf_br_reset", perf_branches, 32'd0);
    check("perf_mp_reset", perf_mispredicts, 32'd0);
    for (int i = 0; i < 10; i++) begin
      drive_ex(0, 32'h10c, OPB, 0, 32'h0, (i < 3), 32'h110);
      tick();
    end
    idle_ex();
    check("perf_branches", perf_branches, 32'd10);
    check("perf_mispredicts", perf_mispredicts, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
